// File: rtl/led_period_meter.sv
// led_period_meter: measures the period of a slow external signal in clk cycles
// and flags whether it lies inside [MIN_CYC, MAX_CYC], with an abort on timeout.
//
// Ports:
//   i_clk      system clock, single domain
//   i_reset    synchronous active-high reset
//   i_sig_in   signal under measurement, asynchronous to i_clk
//   i_start    one-cycle request to begin a measurement (honoured in IDLE only)
//   o_busy     high while waiting for the first edge or measuring
//   o_valid    one-cycle pulse when a result is published
//   o_period   measured period in clk cycles (TIMEOUT_CYC on timeout)
//   o_pass     period inside the window
//   o_fail     period outside the window, or timeout
//   o_timeout  no qualifying edge within TIMEOUT_CYC cycles
module led_period_meter #(
  parameter int CNT_W       = 26,
  parameter int MIN_CYC     = 19_600_000,
  parameter int MAX_CYC     = 20_400_000,
  parameter int TIMEOUT_CYC = 40_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_sig_in,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_period,
  output logic             o_pass,
  output logic             o_fail,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] LP_MIN = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_CYC);
  localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_ZRO = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             w_rise;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic             r_pass;
  logic             w_pass_nxt;
  logic             r_fail;
  logic             w_fail_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;

  logic             w_in_win;
  logic             w_at_to;

  // Two-flop synchronizer plus a history flop for edge detection.
  // The fixed pipeline delay cancels out between the two edges.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise   = r_sync2 & ~r_prev;
  assign w_in_win = (r_cnt >= LP_MIN) && (r_cnt <= LP_MAX);
  assign w_at_to  = (r_cnt == LP_TO);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= LP_ZRO;
      r_period  <= LP_ZRO;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_pass    <= w_pass_nxt;
      r_fail    <= w_fail_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // cnt is 1 in the first cycle after an edge, so at the next
  // detected edge it equals the distance between the two edges.
  // A rise coinciding with the timeout count still wins.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_pass_nxt    = r_pass;
    w_fail_nxt    = r_fail;
    w_timeout_nxt = r_timeout;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_cnt_nxt     = LP_ONE;
          w_period_nxt  = LP_ZRO;
          w_pass_nxt    = 1'b0;
          w_fail_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = S_ARM;
        end
      end
      S_ARM: begin
        if (w_rise) begin
          w_cnt_nxt   = LP_ONE;
          w_state_nxt = S_MEASURE;
        end else if (w_at_to) begin
          w_period_nxt  = LP_TO;
          w_pass_nxt    = 1'b0;
          w_fail_nxt    = 1'b1;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end
      S_MEASURE: begin
        if (w_rise) begin
          w_period_nxt = r_cnt;
          w_pass_nxt   = w_in_win;
          w_fail_nxt   = ~w_in_win;
          w_state_nxt  = S_DONE;
        end else if (w_at_to) begin
          w_period_nxt  = LP_TO;
          w_pass_nxt    = 1'b0;
          w_fail_nxt    = 1'b1;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_busy    = (r_state == S_ARM) || (r_state == S_MEASURE);
  assign o_valid   = (r_state == S_DONE);
  assign o_period  = r_period;
  assign o_pass    = r_pass;
  assign o_fail    = r_fail;
  assign o_timeout = r_timeout;

endmodule

// File: doc/led_period_meter.md
# led_period_meter

Synthesizable period meter that observes a slow digital output (the lab1 blink LED, nominally 2.4 Hz from the ~48 MHz clock) and reports its period in clock cycles with a pass/fail window check. It replaces oscilloscope verification of the blink frequency: it sits beside the lab1 top level on the board (or in a bench), taps the LED net, and exposes the result on its own status outputs.

## Interface
- CNT_W, 26: width of cycle counter and `period` output
- MIN_CYC, 19_600_000: smallest passing period (inclusive)
- MAX_CYC, 20_400_000: largest passing period (inclusive)
- TIMEOUT_CYC, 40_000_000: cycles without a qualifying edge before abort; must satisfy MAX_CYC < TIMEOUT_CYC < 2^CNT_W
- clk  in  1  system clock (~48 MHz); one clock domain
- reset  in  1  synchronous, active-high reset
- sig_in  in  1  signal under measurement; asynchronous to clk
- start  in  1  one-cycle request to begin a measurement
- busy  out  1  high while a measurement is in progress (ARM or MEASURE)
- valid  out  1  one-cycle pulse when a result is published
- period  out  CNT_W  measured period in clk cycles
- pass  out  1  period within [MIN_CYC, MAX_CYC]
- fail  out  1  period outside the window, or timeout
- timeout  out  1  abort due to missing edge

## Operation
- sig_in passes through a 2-flop synchronizer; a third flop holds the previous synchronized value. `rise` = sync & ~prev.
- FSM states: IDLE, ARM, MEASURE, DONE.
- IDLE: busy=0. On start: cnt←1, clear pass/fail/timeout/period, go ARM. A `rise` in the same cycle as start is ignored.
- ARM: waiting for the first rising edge. On `rise`: cnt←1, go MEASURE. Otherwise cnt←cnt+1. If cnt==TIMEOUT_CYC without `rise`: timeout.
- MEASURE: on `rise`: period←cnt, pass←(MIN_CYC≤cnt≤MAX_CYC), fail←~pass, go DONE. Otherwise cnt←cnt+1. If cnt==TIMEOUT_CYC without `rise`: timeout.
- Timeout (from ARM or MEASURE): period←TIMEOUT_CYC, timeout←1, fail←1, pass←0, go DONE.
- DONE: valid=1 for exactly this cycle, then go IDLE. period/pass/fail/timeout hold until the next accepted start or reset.
- start while busy or in DONE is ignored.
- Comparisons are unsigned at CNT_W bits. cnt never exceeds TIMEOUT_CYC, so it never wraps.
- pass and fail are never both 1. After a result, exactly one of them is 1.

## Timing
- Reset: state=IDLE, cnt=0, sync/prev flops=0, busy=0, valid=0, period=0, pass=0, fail=0, timeout=0.
- Reset asserted mid-measurement aborts the measurement. Outputs take their reset values on the next edge and no valid pulse is produced.
- sig_in rising change sampled at edge k → `rise` in cycle k+2. The latency is constant, so the reported period equals the true period quantized to clk cycles.
- If rises are detected in cycles e1 and e2, period = e2−e1. valid asserts in cycle e2+1. busy falls in the cycle valid rises.
- Timeout result: valid occurs TIMEOUT_CYC+1 cycles after entering ARM or MEASURE.
- Earliest next start is accepted the cycle after valid.

## Test plan
Test parameters: CNT_W=8, MIN_CYC=18, MAX_CYC=22, TIMEOUT_CYC=40.
- Reset held 3 cycles with sig_in toggling → all outputs 0, busy=0, no valid.
- start, then a square wave of period 20 → single valid pulse; period=20, pass=1, fail=0, timeout=0; valid 1 cycle after the second detected rise.
- Boundaries, one run each at periods 18, 22, 17, 23 → pass=1 for 18 and 22; fail=1 for 17 and 23; period equals the stimulus period in every run.
- sig_in held low after start → valid exactly 41 cycles after start; period=40, timeout=1, fail=1, pass=0. Repeat with a single rise and then constant low → same result, timed from that rise.
- start pulsed again during MEASURE → ignored, result unchanged (period 20); reset asserted mid-MEASURE → no valid, outputs 0; following start measures correctly.
- Glitch: start coincident with a sig_in rise → that rise ignored; measurement begins at the next rise.
